mul_rr_seq_16: RTL

- Shared multi-cycle signed multiplier unit for the CPU datapath.
- Two requesters (e.g. the execute stage and the address/MAC path) share one radix-2 Booth shift-add engine.
- Round-robin arbitration, valid/ready handshakes on both request ports and on the result port.
- Result is the exact 2*WIDTH-bit signed product, tagged with the requester ID.

---
 rtl/mul_rr_seq_16.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mul_rr_seq_16.sv
// Shared signed multiplier: two requesters are arbitrated round-robin onto one
// radix-2 Booth shift-add engine; each result carries the owning requester's tag.
module mul_rr_seq_16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_tag,
  output logic [2*WIDTH-1:0] res_product,
  output logic [WIDTH-1:0]   res_low,
  output logic               busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         r_state;
  logic               r_lastGrant;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_qm1;
  logic [WIDTH-1:0]   r_a;
  logic               r_tag;
  logic [2*WIDTH-1:0] r_product;
  logic               r_resValid;

  logic               w_grant;
  logic               w_accept;
  logic [WIDTH:0]     w_aExt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_accNext;
  logic [WIDTH-1:0]   w_qNext;
  logic               w_lastStep;

  // On a tie the requester that did not win last time gets the engine.
  assign w_grant    = (req0_valid && req1_valid) ? ~r_lastGrant : req1_valid;
  assign req0_ready = !rst && (r_state == IDLE) && !w_grant && req0_valid;
  assign req1_ready = !rst && (r_state == IDLE) &&  w_grant && req1_valid;
  assign w_accept   = req0_ready || req1_ready;

  // The accumulator is one bit wider so negating the most negative operand is exact.
  assign w_aExt = {r_a[WIDTH-1], r_a};

  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b10:   w_sum = r_acc - w_aExt;
      2'b01:   w_sum = r_acc + w_aExt;
      default: w_sum = r_acc;
    endcase
  end

  assign w_accNext  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_qNext    = {w_sum[0], r_q[WIDTH-1:1]};
  assign w_lastStep = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_qm1       <= 1'b0;
      r_a         <= '0;
      r_tag       <= 1'b0;
      r_product   <= '0;
      r_resValid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a         <= w_grant ? req1_a : req0_a;
            r_q         <= w_grant ? req1_b : req0_b;
            r_qm1       <= 1'b0;
            r_tag       <= w_grant;
            r_lastGrant <= w_grant;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_state     <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_accNext;
          r_q   <= w_qNext;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CNT_W'(1);
          // The product fits in 2*WIDTH bits, so the accumulator's top bit is pure sign.
          if (w_lastStep) begin
            r_product  <= {w_accNext[WIDTH-1:0], w_qNext};
            r_resValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid   = r_resValid;
  assign res_tag     = r_tag;
  assign res_product = r_product;
  assign res_low     = r_product[WIDTH-1:0];
  assign busy        = (r_state != IDLE);

endmodule
